// File: rtl/jedro_2_decoder.sv
// RV32I/E (+M) decoder: one decode stage with valid/ready on both sides, a 2-entry
// output/skid store so upstream ready comes from a flop, and a trap on illegal words.
module jedro_2_decoder #(
  parameter bit          RV32E          = 1'b0,
  parameter bit          HAS_M          = 1'b0,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [31:0]               instr_rdata_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [3:0]                alu_op_sel_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [31:0]               imm_o,
  output logic                      lsu_en_o,
  output logic [3:0]                lsu_ctrl_o,
  output logic                      muldiv_o,
  output logic                      illegal_instr_o
);

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef struct packed {
    logic [3:0]                alu_op;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rd_we;
    logic [31:0]               imm;
    logic                      lsu_en;
    logic [3:0]                lsu_ctrl;
    logic                      muldiv;
    logic                      illegal;
  } bundle_t;

  typedef enum logic {RUN, TRAP} state_e;

  state_e  state_q, state_d;
  bundle_t dec, out_q, skid_q;
  logic    out_valid_q, skid_valid_q, ready_q;
  logic    accept, out_free, skid_valid_d;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2, use_rd, bad;

  assign instr  = instr_rdata_i;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign rd_f   = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    bad     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        dec.imm = imm_i; dec.lsu_en = 1'b1; dec.lsu_ctrl = {1'b0, funct3};
        bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_s; dec.lsu_en = 1'b1; dec.lsu_ctrl = {1'b1, funct3};
        bad = (funct3 > 3'd2);
      end
      OPC_OPIMM: begin
        use_rs1 = 1'b1; use_rd = 1'b1;
        dec.imm    = imm_i;
        dec.alu_op = (funct3 == 3'd5) ? {instr[30], funct3} : {1'b0, funct3};
        bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
              ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        dec.alu_op = {instr[30], funct3};
        if (funct7 == 7'h20)      bad = (funct3 != 3'd0) && (funct3 != 3'd5);
        else if (funct7 == 7'h01) begin
          bad        = !HAS_M;
          dec.muldiv = HAS_M;
        end
        else                      bad = (funct7 != 7'h00);
      end
      OPC_LUI, OPC_AUIPC: begin
        use_rd = 1'b1; dec.imm = imm_u;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.imm = imm_b;
        bad = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        use_rd = 1'b1; dec.imm = imm_j;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; use_rd = 1'b1; dec.imm = imm_i;
      end
      OPC_MISCMEM: dec.imm = imm_i;
      OPC_SYSTEM: begin
        dec.imm = imm_i;
        bad = (instr != 32'h0000_0073) && (instr != 32'h0010_0073);
      end
      default: bad = 1'b1;
    endcase
    if (RV32E)
      bad = bad || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4]);
    dec.rs1     = use_rs1 ? rs1_f[REG_ADDR_WIDTH-1:0] : '0;
    dec.rs2     = use_rs2 ? rs2_f[REG_ADDR_WIDTH-1:0] : '0;
    dec.rd      = use_rd  ? rd_f[REG_ADDR_WIDTH-1:0]  : '0;
    dec.rd_we   = use_rd && (rd_f != 5'd0) && !bad;
    dec.lsu_en  = dec.lsu_en && !bad;
    dec.muldiv  = dec.muldiv && !bad;
    dec.illegal = bad;
  end

  // ready_q already implies RUN with an empty skid entry; flush drops the offered beat
  assign accept   = instr_valid_i && ready_q && !flush_i;
  assign out_free = !out_valid_q || dec_ready_i;

  always_comb begin
    skid_valid_d = skid_valid_q ? !out_free : (accept && !out_free);
    state_d      = state_q;
    if (flush_i)                                   state_d = RUN;
    else if (state_q == RUN && accept && dec.illegal) state_d = TRAP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
      ready_q <= (state_d == RUN) && !skid_valid_d;
    end
  end

  assign instr_ready_o   = ready_q;
  assign dec_valid_o     = out_valid_q;
  assign alu_op_sel_o    = out_q.alu_op;
  assign rs1_addr_o      = out_q.rs1;
  assign rs2_addr_o      = out_q.rs2;
  assign rd_addr_o       = out_q.rd;
  assign rd_we_o         = out_q.rd_we;
  assign imm_o           = out_q.imm;
  assign lsu_en_o        = out_q.lsu_en;
  assign lsu_ctrl_o      = out_q.lsu_ctrl;
  assign muldiv_o        = out_q.muldiv;
  assign illegal_instr_o = out_q.illegal;

endmodule

// File: tb/tb_jedro_2_decoder.sv
// Scoreboard bench for jedro_2_decoder: an RV32I instance and an RV32E+M instance share
// stimulus; each accepted word is decoded by a reference model and compared on output.
module tb_jedro_2_decoder;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic        lsu_en;
    logic [3:0]  lsu_ctrl;
    logic        muldiv;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] rdata = '0;
  logic        dec_ready = 1'b0;

  logic        rdy0, dv0, we0, lsu0, md0, ill0;
  logic [3:0]  alu0, lctl0;
  logic [4:0]  rs1_0, rs2_0, rd0;
  logic [31:0] imm0;
  logic        rdy1, dv1, we1, lsu1, md1, ill1;
  logic [3:0]  alu1, lctl1;
  logic [3:0]  rs1_1, rs2_1, rd1;
  logic [31:0] imm1;

  int n_vec = 0;
  int n_err = 0;
  bit sb_on = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  jedro_2_decoder #(.RV32E(1'b0), .HAS_M(1'b0), .REG_ADDR_WIDTH(5)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(in_valid),
    .instr_ready_o(rdy0), .instr_rdata_i(rdata), .dec_valid_o(dv0), .dec_ready_i(dec_ready),
    .alu_op_sel_o(alu0), .rs1_addr_o(rs1_0), .rs2_addr_o(rs2_0), .rd_addr_o(rd0),
    .rd_we_o(we0), .imm_o(imm0), .lsu_en_o(lsu0), .lsu_ctrl_o(lctl0), .muldiv_o(md0),
    .illegal_instr_o(ill0));

  jedro_2_decoder #(.RV32E(1'b1), .HAS_M(1'b1), .REG_ADDR_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_valid_i(in_valid),
    .instr_ready_o(rdy1), .instr_rdata_i(rdata), .dec_valid_o(dv1), .dec_ready_i(dec_ready),
    .alu_op_sel_o(alu1), .rs1_addr_o(rs1_1), .rs2_addr_o(rs2_1), .rd_addr_o(rd1),
    .rd_we_o(we1), .imm_o(imm1), .lsu_en_o(lsu1), .lsu_ctrl_o(lctl1), .muldiv_o(md1),
    .illegal_instr_o(ill1));

  exp_t act0, act1;
  assign act0 = {alu0, rs1_0, rs2_0, rd0, we0, imm0, lsu0, lctl0, md0, ill0};
  assign act1 = {alu1, 1'b0, rs1_1, 1'b0, rs2_1, 1'b0, rd1, we1, imm1, lsu1, lctl1, md1, ill1};

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference decode from the ISA field definitions using integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w, input bit rv32e, input bit has_m);
    exp_t r = '0;
    int sw  = w;
    int op  = int'(w & 32'h7F);
    int f3  = int'((w >> 12) & 7);
    int f7  = int'(w >> 25);
    int a1  = int'((w >> 15) & 31);
    int a2  = int'((w >> 20) & 31);
    int ad  = int'((w >> 7) & 31);
    int ii  = sw >>> 20;
    int is  = ((sw >>> 25) <<< 5) | ad;
    int ib  = ((sw >>> 31) <<< 12) | int'(((w >> 7) & 1) << 11) |
              int'(((w >> 25) & 63) << 5) | int'(((w >> 8) & 15) << 1);
    int iu  = int'(w & 32'hFFFF_F000);
    int ij  = ((sw >>> 31) <<< 20) | int'(((w >> 12) & 255) << 12) |
              int'(((w >> 20) & 1) << 11) | int'(((w >> 21) & 1023) << 1);
    int mask = rv32e ? 15 : 31;
    bit u1 = 0, u2 = 0, ud = 0, bad = 0, ls = 0, md = 0;
    case (op)
      'h03: begin u1 = 1; ud = 1; r.imm = ii; ls = 1; r.lsu_ctrl = 4'(f3); bad = f3 inside {3, 6, 7}; end
      'h23: begin u1 = 1; u2 = 1; r.imm = is; ls = 1; r.lsu_ctrl = 4'(8 + f3); bad = f3 > 2; end
      'h13: begin
        u1 = 1; ud = 1; r.imm = ii;
        r.alu = 4'((f3 == 5) ? int'((w >> 30) & 1) * 8 + f3 : f3);
        if (f3 == 1) bad = f7 != 0;
        if (f3 == 5) bad = !(f7 inside {0, 'h20});
      end
      'h33: begin
        u1 = 1; u2 = 1; ud = 1;
        r.alu = 4'(int'((w >> 30) & 1) * 8 + f3);
        if (f7 == 'h01) begin bad = !has_m; md = has_m; end
        else if (f7 == 'h20) bad = !(f3 inside {0, 5});
        else bad = f7 != 0;
      end
      'h37, 'h17: begin ud = 1; r.imm = iu; end
      'h63: begin u1 = 1; u2 = 1; r.imm = ib; bad = f3 inside {2, 3}; end
      'h6F: begin ud = 1; r.imm = ij; end
      'h67: begin u1 = 1; ud = 1; r.imm = ii; end
      'h0F: r.imm = ii;
      'h73: begin r.imm = ii; bad = !(w inside {32'h73, 32'h0010_0073}); end
      default: bad = 1;
    endcase
    if (rv32e && ((u1 && a1 >= 16) || (u2 && a2 >= 16) || (ud && ad >= 16))) bad = 1;
    r.rs1    = u1 ? 5'(a1 & mask) : 5'd0;
    r.rs2    = u2 ? 5'(a2 & mask) : 5'd0;
    r.rd     = ud ? 5'(ad & mask) : 5'd0;
    r.we     = ud && ad != 0 && !bad;
    r.lsu_en = ls && !bad;
    r.muldiv = md && !bad;
    r.ill    = bad;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 15) == 0) return w;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h23;  2: w[6:0] = 7'h13;  3: w[6:0] = 7'h33;
      4: w[6:0] = 7'h37;  5: w[6:0] = 7'h17;  6: w[6:0] = 7'h63;  7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;  9: w[6:0] = 7'h0F;  default: w[6:0] = 7'h73;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) != 0) begin w[24] = 1'b0; w[19] = 1'b0; w[11] = 1'b0; end
    if (w[6:0] == 7'h73 && $urandom_range(0, 2) != 0)
      w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
    return w;
  endfunction

  // Flush discards everything held and the beat on offer; otherwise pop on drain, push on accept.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (dv0 && dec_ready) begin
          if (q0.size() == 0) chk("dut0_unexpected_output", 64'(act0), 64'h1);
          else chk("dut0_bundle", 64'(act0), 64'(q0.pop_front()));
        end
        if (dv1 && dec_ready) begin
          if (q1.size() == 0) chk("dut1_unexpected_output", 64'(act1), 64'h1);
          else chk("dut1_bundle", 64'(act1), 64'(q1.pop_front()));
        end
        if (in_valid && rdy0) q0.push_back(ref_decode(rdata, 1'b0, 1'b0));
        if (in_valid && rdy1) q1.push_back(ref_decode(rdata, 1'b1, 1'b1));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w);
    in_valid = 1'b1;
    rdata    = w;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    int idx;
    bit stuck;
    logic [31:0] words [3];
    repeat (3) cyc();
    chk("reset_outputs_dut0", 64'({rdy0, dv0, act0}), 64'h0);
    chk("reset_outputs_dut1", 64'({rdy1, dv1, act1}), 64'h0);
    rst   = 1'b0;
    sb_on = 1'b1;
    cyc();
    chk("ready_after_reset", 64'({rdy0, rdy1}), 64'h3);

    dec_ready = 1'b1;
    offer(32'h0050_0093);
    chk("addi_valid_rd_we", 64'({dv0, rd0, we0}), 64'({1'b1, 5'd1, 1'b1}));
    chk("addi_imm_alu", 64'({imm0, alu0}), 64'({32'd5, 4'd0}));

    offer(32'hFE11_2E23);
    chk("sw_lsu", 64'({lsu0, lctl0, we0}), 64'({1'b1, 4'b1010, 1'b0}));
    chk("sw_imm", 64'(imm0), 64'(32'hFFFF_FFFC));
    cyc();

    dec_ready = 1'b0;
    words[0] = 32'h0010_0093;
    words[1] = 32'h0020_0113;
    words[2] = 32'h0030_0193;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      in_valid = 1'b1;
      rdata    = words[idx < 3 ? idx : 2];
      acc      = rdy0;
      cyc();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("skid_accept_count", 64'(idx), 64'd2);
    chk("skid_ready_low", 64'({rdy0, rdy1, dv0, rd0}), 64'({1'b0, 1'b0, 1'b1, 5'd1}));
    dec_ready = 1'b1;
    repeat (4) cyc();
    chk("skid_drained", 64'({dv0, dv1, rdy0, rdy1}), 64'b0011);

    offer(32'h0000_0000);
    chk("zero_word_illegal", 64'({dv0, ill0, we0, lsu0}), 64'b1100);
    stuck = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (rdy0 || rdy1) stuck = 1'b0;
      in_valid = 1'b1;
      rdata    = 32'h0050_0093;
      cyc();
    end
    in_valid = 1'b0;
    chk("trap_ready_low_10", 64'(stuck), 64'd1);
    do_flush();
    chk("flush_recovers", 64'({dv0, dv1, rdy0, rdy1}), 64'b0011);

    offer(32'h0220_8033);
    chk("mul_no_m_illegal", 64'({dv0, ill0, md0}), 64'b110);
    chk("mul_with_m", 64'({dv1, ill1, md1, we1}), 64'b1010);
    do_flush();

    offer(32'h0100_0813);
    chk("rv32e_x16_illegal", 64'({dv1, ill1, we1}), 64'b110);
    chk("rv32i_x16_legal", 64'({dv0, ill0, we0, rd0}), 64'({3'b101, 5'd16}));
    do_flush();

    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rdata     = rand_instr();
      dec_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      cyc();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    dec_ready = 1'b1;
    idx = 0;
    while ((q0.size() != 0 || q1.size() != 0) && idx < 20) begin
      cyc();
      idx++;
    end
    chk("scoreboard_drained", 64'({q0.size() == 0, q1.size() == 0}), 64'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
